hsv_core_alu_issue: RTL and testbench

Issue stage directly upstream of the two-substage ALU. Accepts decoded ALU instructions in order, holds each one while its source or destination registers are still owed a write-back, reads the register file once the hazard clears, and presents operands plus decoded payload to the ALU over a valid/ready handshake. A 32-entry scoreboard tracks in-flight destination registers. It is cleared by write-back and wiped by flush.

---
 rtl/hsv_core_alu_issue.sv | 163 ++++++++++++++++
 tb/tb_hsv_core_alu_issue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_core_alu_issue.sv
// Issue stage in front of the two-substage ALU: holds instructions in a wait
// register until the scoreboard shows no pending write-back, then loads the output register.
module hsv_core_alu_issue #(
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clk_core,
    input  logic                 rst_core,
    input  logic                 flush_req,
    output logic                 flush_ack,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rs1_addr,
    input  logic [4:0]           in_rs2_addr,
    input  logic [4:0]           in_rd_addr,
    input  logic                 in_uses_rs1,
    input  logic                 in_uses_rs2,
    input  logic                 in_writes_rd,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic [4:0]           rf_rs1_addr,
    output logic [4:0]           rf_rs2_addr,
    input  logic [31:0]          rf_rs1_data,
    input  logic [31:0]          rf_rs2_data,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_rs1,
    output logic [31:0]          out_rs2,
    output logic [4:0]           out_rd_addr,
    output logic                 out_writes_rd,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [31:0]          busy_mask
);

    logic                 w_valid_r;
    logic [4:0]           w_rs1_r;
    logic [4:0]           w_rs2_r;
    logic [4:0]           w_rd_r;
    logic                 w_uses_rs1_r;
    logic                 w_uses_rs2_r;
    logic                 w_writes_rd_r;
    logic [PAYLOAD_W-1:0] w_payload_r;

    logic                 o_valid_r;
    logic [31:0]          o_rs1_r;
    logic [31:0]          o_rs2_r;
    logic [4:0]           o_rd_r;
    logic                 o_writes_rd_r;
    logic [PAYLOAD_W-1:0] o_payload_r;

    logic [31:0]          sb_r;
    logic [31:0]          sb_next_s;
    logic                 flush_ack_r;

    logic                 hazard_s;
    logic                 issue_s;
    logic                 in_ready_s;
    logic                 load_s;

    // Hazard, issue and accept decisions; no write-back bypass on the scoreboard.
    always_comb begin
        hazard_s   = (w_uses_rs1_r  & sb_r[w_rs1_r]) |
                     (w_uses_rs2_r  & sb_r[w_rs2_r]) |
                     (w_writes_rd_r & sb_r[w_rd_r]);
        issue_s    = w_valid_r & ~hazard_s & (~o_valid_r | out_ready) & ~flush_req;
        in_ready_s = ~flush_req & (~w_valid_r | issue_s);
        load_s     = in_valid & in_ready_s;
    end

    // Scoreboard next state: flush wipes, issue set takes priority over write-back clear.
    always_comb begin
        sb_next_s = sb_r;
        if (flush_req) begin
            sb_next_s = 32'd0;
        end else begin
            if (wb_valid && (wb_rd_addr != 5'd0)) begin
                sb_next_s[wb_rd_addr] = 1'b0;
            end else begin
                sb_next_s = sb_next_s;
            end
            if (issue_s && w_writes_rd_r && (w_rd_r != 5'd0)) begin
                sb_next_s[w_rd_r] = 1'b1;
            end else begin
                sb_next_s = sb_next_s;
            end
        end
        sb_next_s[0] = 1'b0;
    end

    // Wait register: accepts from decode, empties when its instruction issues.
    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            w_valid_r     <= 1'b0;
            w_rs1_r       <= 5'd0;
            w_rs2_r       <= 5'd0;
            w_rd_r        <= 5'd0;
            w_uses_rs1_r  <= 1'b0;
            w_uses_rs2_r  <= 1'b0;
            w_writes_rd_r <= 1'b0;
            w_payload_r   <= {PAYLOAD_W{1'b0}};
        end else if (flush_req) begin
            w_valid_r <= 1'b0;
        end else if (load_s) begin
            w_valid_r     <= 1'b1;
            w_rs1_r       <= in_rs1_addr;
            w_rs2_r       <= in_rs2_addr;
            w_rd_r        <= in_rd_addr;
            w_uses_rs1_r  <= in_uses_rs1;
            w_uses_rs2_r  <= in_uses_rs2;
            w_writes_rd_r <= in_writes_rd;
            w_payload_r   <= in_payload;
        end else if (issue_s) begin
            w_valid_r <= 1'b0;
        end
    end

    // Output register: data changes only on issue, so it stays stable under backpressure.
    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            o_valid_r     <= 1'b0;
            o_rs1_r       <= 32'd0;
            o_rs2_r       <= 32'd0;
            o_rd_r        <= 5'd0;
            o_writes_rd_r <= 1'b0;
            o_payload_r   <= {PAYLOAD_W{1'b0}};
        end else if (flush_req) begin
            o_valid_r <= 1'b0;
        end else if (issue_s) begin
            o_valid_r     <= 1'b1;
            o_rs1_r       <= w_uses_rs1_r ? rf_rs1_data : 32'd0;
            o_rs2_r       <= w_uses_rs2_r ? rf_rs2_data : 32'd0;
            o_rd_r        <= w_rd_r;
            o_writes_rd_r <= w_writes_rd_r;
            o_payload_r   <= w_payload_r;
        end else if (o_valid_r && out_ready) begin
            o_valid_r <= 1'b0;
        end
    end

    // Scoreboard and flush acknowledge registers.
    always_ff @(posedge clk_core or negedge rst_core) begin
        if (!rst_core) begin
            sb_r        <= 32'd0;
            flush_ack_r <= 1'b0;
        end else begin
            sb_r        <= sb_next_s;
            flush_ack_r <= flush_req;
        end
    end

    assign in_ready      = in_ready_s;
    assign rf_rs1_addr   = w_rs1_r;
    assign rf_rs2_addr   = w_rs2_r;
    assign out_valid     = o_valid_r;
    assign out_rs1       = o_rs1_r;
    assign out_rs2       = o_rs2_r;
    assign out_rd_addr   = o_rd_r;
    assign out_writes_rd = o_writes_rd_r;
    assign out_payload   = o_payload_r;
    assign busy_mask     = sb_r;
    assign flush_ack     = flush_ack_r;

endmodule

// File: tb/tb_hsv_core_alu_issue.sv
// Directed self-checking bench for hsv_core_alu_issue with a behavioural
// register file and hand-computed expectations.
module tb_hsv_core_alu_issue;

    localparam int PW = 64;

    logic          clk_core = 1'b0;
    logic          rst_core;
    logic          flush_req;
    logic          flush_ack;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rs1_addr;
    logic [4:0]    in_rs2_addr;
    logic [4:0]    in_rd_addr;
    logic          in_uses_rs1;
    logic          in_uses_rs2;
    logic          in_writes_rd;
    logic [PW-1:0] in_payload;
    logic [4:0]    rf_rs1_addr;
    logic [4:0]    rf_rs2_addr;
    logic [31:0]   rf_rs1_data;
    logic [31:0]   rf_rs2_data;
    logic          wb_valid;
    logic [4:0]    wb_rd_addr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_rs1;
    logic [31:0]   out_rs2;
    logic [4:0]    out_rd_addr;
    logic          out_writes_rd;
    logic [PW-1:0] out_payload;
    logic [31:0]   busy_mask;

    int n_checks = 0;
    int n_fail   = 0;

    hsv_core_alu_issue #(.PAYLOAD_W(PW)) dut (
        .clk_core(clk_core), .rst_core(rst_core), .flush_req(flush_req), .flush_ack(flush_ack),
        .in_valid(in_valid), .in_ready(in_ready), .in_rs1_addr(in_rs1_addr),
        .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr), .in_uses_rs1(in_uses_rs1),
        .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd), .in_payload(in_payload),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr), .rf_rs1_data(rf_rs1_data),
        .rf_rs2_data(rf_rs2_data), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_rd_addr(out_rd_addr), .out_writes_rd(out_writes_rd), .out_payload(out_payload),
        .busy_mask(busy_mask)
    );

    always #5 clk_core = ~clk_core;

    function automatic logic [31:0] rf_model(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        else if (a == 5'd5) return 32'hDEADBEEF;
        else return 32'h1000_0000 | {27'd0, a};
    endfunction

    assign rf_rs1_data = rf_model(rf_rs1_addr);
    assign rf_rs2_data = rf_model(rf_rs2_addr);

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic wr, input logic [63:0] pl);
        in_valid     = 1'b1;
        in_rs1_addr  = rs1;
        in_rs2_addr  = rs2;
        in_rd_addr   = rd;
        in_uses_rs1  = u1;
        in_uses_rs2  = u2;
        in_writes_rd = wr;
        in_payload   = pl;
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    initial begin
        rst_core = 1'b0; flush_req = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
        wb_rd_addr = 5'd0; out_ready = 1'b1;
        in_rs1_addr = 5'd0; in_rs2_addr = 5'd0; in_rd_addr = 5'd0;
        in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_writes_rd = 1'b0; in_payload = 64'd0;
        #3;
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy_mask, 32'd0);
        check_eq("rst_flush_ack", flush_ack, 1'b0);
        check_eq("rst_out_payload", out_payload, 64'd0);
        tick();
        tick();
        rst_core = 1'b1;

        // back-to-back independent writes of x1..x3
        offer(5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b1, 64'h11);
        #1 check_eq("b2b_ready0", in_ready, 1'b1);
        tick();
        offer(5'd0, 5'd0, 5'd2, 1'b0, 1'b0, 1'b1, 64'h22);
        #1 check_eq("b2b_ready1", in_ready, 1'b1);
        check_eq("b2b_ov_early", out_valid, 1'b0);
        tick();
        check_eq("b2b_ov1", out_valid, 1'b1);
        check_eq("b2b_rd1", out_rd_addr, 5'd1);
        check_eq("b2b_pl1", out_payload, 64'h11);
        offer(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 64'h33);
        tick();
        check_eq("b2b_ov2", out_valid, 1'b1);
        check_eq("b2b_rd2", out_rd_addr, 5'd2);
        in_valid = 1'b0;
        tick();
        check_eq("b2b_ov3", out_valid, 1'b1);
        check_eq("b2b_rd3", out_rd_addr, 5'd3);
        check_eq("b2b_busy", busy_mask, 32'h0000000E);
        tick();
        check_eq("b2b_drain", out_valid, 1'b0);
        pulse_flush();
        #1 check_eq("flush_clr_busy", busy_mask, 32'd0);

        // RAW stall on x5
        offer(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 64'hA0);
        tick();
        offer(5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b1, 64'hB0);
        tick();
        in_valid = 1'b0;
        #1 check_eq("raw_in_ready", in_ready, 1'b0);
        tick();
        check_eq("raw_ov_stall", out_valid, 1'b0);
        check_eq("raw_busy", busy_mask, 32'h00000020);
        check_eq("raw_in_ready2", in_ready, 1'b0);
        tick();
        check_eq("raw_ov_stall2", out_valid, 1'b0);
        wb_valid = 1'b1; wb_rd_addr = 5'd5;
        tick();
        wb_valid = 1'b0;
        check_eq("raw_ov_wbcycle", out_valid, 1'b0);
        check_eq("raw_busy_wb", busy_mask, 32'd0);
        tick();
        check_eq("raw_ov_issue", out_valid, 1'b1);
        check_eq("raw_rs1", out_rs1, 32'hDEADBEEF);
        check_eq("raw_rs2_zeroed", out_rs2, 32'd0);
        check_eq("raw_rd", out_rd_addr, 5'd6);
        check_eq("raw_pl", out_payload, 64'hB0);
        check_eq("raw_busy6", busy_mask, 32'h00000040);
        tick();
        wb_valid = 1'b1; wb_rd_addr = 5'd6;
        tick();
        wb_valid = 1'b0;

        // x0 never causes a hazard
        offer(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 64'hC0);
        tick();
        offer(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 64'hC1);
        #1 check_eq("x0_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check_eq("x0_ov1", out_valid, 1'b1);
        check_eq("x0_busy1", busy_mask, 32'd0);
        tick();
        check_eq("x0_ov2", out_valid, 1'b1);
        check_eq("x0_pl2", out_payload, 64'hC1);
        check_eq("x0_busy2", busy_mask, 32'd0);
        tick();

        // backpressure
        out_ready = 1'b0;
        offer(5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1, 64'hA1);
        tick();
        offer(5'd0, 5'd0, 5'd11, 1'b0, 1'b0, 1'b1, 64'hA2);
        #1 check_eq("bp_ready_w", in_ready, 1'b1);
        tick();
        check_eq("bp_ov", out_valid, 1'b1);
        check_eq("bp_pl1", out_payload, 64'hA1);
        check_eq("bp_full", in_ready, 1'b0);
        offer(5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1, 64'hA3);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("bp_hold_pl", out_payload, 64'hA1);
            check_eq("bp_hold_rd", out_rd_addr, 5'd10);
            check_eq("bp_hold_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1 check_eq("bp_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check_eq("bp_next_pl", out_payload, 64'hA2);
        check_eq("bp_next_ov", out_valid, 1'b1);
        tick();
        check_eq("bp_last_pl", out_payload, 64'hA3);
        tick();
        check_eq("bp_drain", out_valid, 1'b0);
        check_eq("bp_busy", busy_mask, 32'h00001C00);
        pulse_flush();

        // flush during stall with a write-back of x7 in the same cycle
        offer(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 64'hD0);
        tick();
        offer(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 64'hD1);
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("fl_stall_busy", busy_mask, 32'h00000080);
        flush_req = 1'b1; wb_valid = 1'b1; wb_rd_addr = 5'd7;
        #1 check_eq("fl_in_ready", in_ready, 1'b0);
        tick();
        flush_req = 1'b0; wb_valid = 1'b0;
        check_eq("fl_ov", out_valid, 1'b0);
        check_eq("fl_busy", busy_mask, 32'd0);
        check_eq("fl_ack", flush_ack, 1'b1);
        tick();
        check_eq("fl_ov_after", out_valid, 1'b0);
        check_eq("fl_ack_drop", flush_ack, 1'b0);

        // WAW on x9
        offer(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 64'hE0);
        tick();
        offer(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 64'hE1);
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("waw_stall_ov", out_valid, 1'b0);
        check_eq("waw_stall_ready", in_ready, 1'b0);
        wb_valid = 1'b1; wb_rd_addr = 5'd9;
        tick();
        wb_valid = 1'b0;
        check_eq("waw_wb_ov", out_valid, 1'b0);
        tick();
        check_eq("waw_issue_ov", out_valid, 1'b1);
        check_eq("waw_issue_pl", out_payload, 64'hE1);
        check_eq("waw_busy", busy_mask, 32'h00000200);

        // same-cycle set and clear of x4: set wins
        offer(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 64'hF0);
        tick();
        in_valid = 1'b0;
        wb_valid = 1'b1; wb_rd_addr = 5'd4;
        tick();
        wb_valid = 1'b0;
        check_eq("setclr_busy", busy_mask, 32'h00000210);

        // asynchronous mid-operation reset
        offer(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 64'h99);
        tick();
        tick();
        #2 rst_core = 1'b0;
        #1;
        check_eq("arst_ov", out_valid, 1'b0);
        check_eq("arst_busy", busy_mask, 32'd0);
        check_eq("arst_pl", out_payload, 64'd0);
        in_valid = 1'b0;
        #1 check_eq("arst_ready", in_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
